uart_tx_port: RTL and testbench
===============================

# uart_tx_port

Memory-mapped UART transmitter answering as a responder on the control unit's data-memory bus (enable/rw/address/write-data/read-data), alongside the main memory. Stores written bytes in a small FIFO and serialises them 8N1, LSB first, on a single output line. Drives a `hit` flag so the top level can mux its read data against memory's.

## Interface
- `BASE`, 10'h3F0: word address of register 0; block decodes `BASE`..`BASE+3`.
- `DEPTH_LOG2`, 2: FIFO depth = 2**DEPTH_LOG2 bytes.
- `DEFAULT_DIV`, 16'd434: divisor loaded at reset (clocks per bit).
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: asynchronous, active-low.
- `enable` in 1: bus request valid this cycle.
- `rw` in 1: 1 = write, 0 = read.
- `add` in 10: word address.
- `wData` in 32: write data.
- `rData` out 32: registered read data.
- `hit` out 1: registered; 1 when `rData` holds this block's response.
- `tx` out 1: serial line, idle high.
- `irq` out 1: level, 1 while FIFO empty and shifter idle.

## Operation
- Registers:
  - `BASE+0` DATA: write pushes `wData[7:0]`; read returns 0.
  - `BASE+1` STATUS, read-only: bit0 busy (FSM not IDLE), bit1 full, bit2 empty, bit3 overrun (sticky), bits[7:4] FIFO count, rest 0. Reading clears overrun.
  - `BASE+2` DIVISOR: R/W, `wData[15:0]`, reads zero-extended. Written 0 is stored as 1.
  - `BASE+3`: reserved, reads 0, writes ignored.
- Address outside `BASE`..`BASE+3`: no state change, `hit`=0, `rData`=0.
- FIFO: circular, pointers wrap modulo depth; count 0..DEPTH.
  - Push while full: byte dropped, overrun set.
  - Push and pop in the same cycle: both performed, count unchanged.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if FIFO non-empty, pop into shift register, latch divisor into `bit_div`, clear baud counter, go to START.
  - START: `tx`=0 for `bit_div` cycles, then DATA.
  - DATA: `tx`=shift[0] for each bit; shift right, bit index 0..7. After bit 7, go to STOP.
  - STOP: `tx`=1 for `bit_div` cycles, then IDLE. The next byte may start on the following cycle.
- A DIVISOR write mid-frame does not affect the current frame; it applies at the next IDLE→START transition.
- Baud counter counts 0..`bit_div`-1, wraps at the bit boundary.

## Timing
- Reset (async, `reset`=0) values: `tx`=1, `rData`=0, `hit`=0, `irq`=1, FSM=IDLE, FIFO empty, overrun=0, divisor=`DEFAULT_DIV`.
- Reset asserted mid-frame forces `tx` high immediately and discards FIFO contents.
- Read latency: request at edge N; `rData` and `hit` valid after edge N+1, held one cycle. With no request, `hit` returns to 0.
- Write takes effect at the edge where `enable`&`rw` are sampled.
- Push at edge N into an empty FIFO with FSM idle: pop and IDLE→START at edge N+1, `tx` falls after edge N+1.
- Frame = 10×`bit_div` cycles from `tx` falling to end of stop bit. Back-to-back bytes have no idle gap.
- STATUS read in the same cycle as an overrun-causing push: returns overrun=1 and clears it.

## Test plan
- Reset, DIVISOR=4, write DATA=0x55 → `tx` low 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, then high 4 cycles (40 cycles total); `irq` 0 during the frame, 1 after.
- DIVISOR=2, write 6 bytes back-to-back with DEPTH 4 → 5 accepted (1 popped immediately, 4 queued), 6th dropped. STATUS reads full=1, overrun=1, count=4; a second STATUS read shows overrun=0.
- Read STATUS at edge N with FIFO empty and idle → `hit`=1 and `rData`=0x00000004 after edge N+1; read address 0x000 → `hit`=0, `rData`=0.
- Write DIVISOR=0 → readback 1; frame of 0xFF lasts 10 cycles.
- Mid-frame DIVISOR change 4→8 → current frame stays 40 cycles; the next frame is 80 cycles.
- Assert `reset` low during DATA bit 3 → `tx`=1 immediately, STATUS=0x04 after release, no resumed transmission.

Source files
------------

// File: rtl/uart_tx_port_if.sv
// Data-memory bus as seen by the UART transmitter.
// The control unit is the master, and this block answers as a slave.
//   enable : request valid this cycle
//   rw     : 1 = write, 0 = read
//   add    : word address
//   wData  : write data
//   rData  : registered read data
//   hit    : rData holds this block's response
interface uart_tx_port_if;
    logic        enable;
    logic        rw;
    logic [9:0]  add;
    logic [31:0] wData;
    logic [31:0] rData;
    logic        hit;

    modport master (output enable, rw, add, wData, input rData, hit);
    modport slave  (input enable, rw, add, wData, output rData, hit);
endinterface

// File: rtl/uart_tx_port.sv
// Memory-mapped 8N1 UART transmitter with a small byte FIFO.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low
//   bus   : data-memory bus slave (enable/rw/add/wData -> rData/hit)
//   tx    : serial output, idle high, LSB first
//   irq   : high while the FIFO is empty and the shifter is idle
// Register map (word offsets from BASE):
//   0 DATA    : write pushes wData[7:0], reads 0
//   1 STATUS  : {count[7:4], overrun, empty, full, busy}; a read clears overrun
//   2 DIVISOR : clocks per bit, 16 bits; a write of 0 is stored as 1
//   3 reserved
//
// state   | meaning
// --------+----------------------------------------------
// S_IDLE  | line high, waiting for a byte in the FIFO
// S_START | start bit (low) for bit_div cycles
// S_DATA  | data bits 0..7, shift[0] on the line
// S_STOP  | stop bit (high); chains straight into the next byte
module uart_tx_port #(
    parameter logic [9:0]  BASE        = 10'h3F0,
    parameter int          DEPTH_LOG2  = 2,
    parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
    input  logic          clk,
    input  logic          reset,
    uart_tx_port_if.slave bus,
    output logic          tx,
    output logic          irq
);
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t                state, state_nxt;
    logic [7:0]            mem [2**DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic                  fifo_full, fifo_empty;
    logic                  push_req, push, drop, pop;
    logic                  overrun;
    logic [15:0]           divisor;
    logic [15:0]           bit_div, bit_div_nxt;
    logic [15:0]           baud, baud_nxt;
    logic [2:0]            bit_idx, idx_nxt;
    logic [7:0]            shift, shift_nxt;
    logic                  tx_nxt, bit_end, start_frame;
    logic [10:0]           add_ext;
    logic                  in_range, acc, wr, rd;
    logic [1:0]            reg_off;
    logic [31:0]           rd_mux, rd_stage_data;
    logic                  rd_stage_hit;
    logic                  unused_wdata;

    assign unused_wdata = ^bus.wData[31:16];

    // Address decode; the low two bits of (add - BASE) select the register.
    assign add_ext  = {1'b0, bus.add};
    assign in_range = (add_ext >= {1'b0, BASE}) && (add_ext <= ({1'b0, BASE} + 11'd3));
    assign reg_off  = bus.add[1:0] - BASE[1:0];
    assign acc      = bus.enable && in_range;
    assign wr       = acc && bus.rw;
    assign rd       = acc && !bus.rw;

    // count never exceeds the depth, so its MSB alone flags full.
    assign fifo_full  = count[DEPTH_LOG2];
    assign fifo_empty = (count == '0);
    assign push_req   = wr && (reg_off == 2'd0);
    assign push       = push_req && !fifo_full;
    assign drop       = push_req && fifo_full;

    assign irq = fifo_empty && (state == S_IDLE);

    // A drop in the same cycle as a STATUS read is reported by that read.
    always_comb begin
        rd_mux = 32'd0;
        case (reg_off)
            2'd1:    rd_mux = {24'd0, 4'(count), overrun | drop, fifo_empty,
                               fifo_full, state != S_IDLE};
            2'd2:    rd_mux = {16'd0, divisor};
            default: rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.wData[7:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            overrun       <= 1'b0;
            divisor       <= DEFAULT_DIV;
            rd_stage_data <= 32'd0;
            rd_stage_hit  <= 1'b0;
            bus.rData     <= 32'd0;
            bus.hit       <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;

            if (rd && (reg_off == 2'd1)) overrun <= 1'b0;
            else if (drop)               overrun <= 1'b1;

            if (wr && (reg_off == 2'd2)) begin
                divisor <= (bus.wData[15:0] == 16'd0) ? 16'd1 : bus.wData[15:0];
            end

            // Response is captured at the request edge and presented one edge later.
            rd_stage_hit  <= rd;
            rd_stage_data <= rd ? rd_mux : 32'd0;
            bus.hit       <= rd_stage_hit;
            bus.rData     <= rd_stage_data;
        end
    end

    assign bit_end = (baud == (bit_div - 16'd1));

    always_comb begin
        state_nxt   = state;
        baud_nxt    = baud + 16'd1;
        idx_nxt     = bit_idx;
        shift_nxt   = shift;
        bit_div_nxt = bit_div;
        start_frame = 1'b0;
        pop         = 1'b0;
        tx_nxt      = 1'b1;
        case (state)
            S_IDLE: begin
                baud_nxt = baud;
                if (!fifo_empty) start_frame = 1'b1;
            end
            S_START: begin
                if (bit_end) begin
                    baud_nxt  = 16'd0;
                    idx_nxt   = 3'd0;
                    state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    baud_nxt  = 16'd0;
                    shift_nxt = {1'b0, shift[7:1]};
                    if (bit_idx == 3'd7) state_nxt = S_STOP;
                    else                 idx_nxt   = bit_idx + 3'd1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    baud_nxt = 16'd0;
                    if (!fifo_empty) start_frame = 1'b1;
                    else             state_nxt   = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        // Divisor is sampled only here, so mid-frame writes wait for the next byte.
        if (start_frame) begin
            pop         = 1'b1;
            shift_nxt   = mem[rd_ptr];
            bit_div_nxt = divisor;
            baud_nxt    = 16'd0;
            state_nxt   = S_START;
        end
        case (state_nxt)
            S_START: tx_nxt = 1'b0;
            S_DATA:  tx_nxt = shift_nxt[0];
            default: tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            baud    <= 16'd0;
            bit_idx <= 3'd0;
            shift   <= 8'd0;
            bit_div <= DEFAULT_DIV;
            tx      <= 1'b1;
        end else begin
            state   <= state_nxt;
            baud    <= baud_nxt;
            bit_idx <= idx_nxt;
            shift   <= shift_nxt;
            bit_div <= bit_div_nxt;
            tx      <= tx_nxt;
        end
    end
endmodule

// File: tb/tb_uart_tx_port.sv
module tb_uart_tx_port;
    logic clk = 1'b0;
    logic reset;
    logic tx, irq;

    uart_tx_port_if bus();

    uart_tx_port dut (.clk(clk), .reset(reset), .bus(bus), .tx(tx), .irq(irq));

    always #5 clk = ~clk;

    localparam logic [9:0] A_DATA = 10'h3F0;
    localparam logic [9:0] A_STAT = 10'h3F1;
    localparam logic [9:0] A_DIV  = 10'h3F2;
    localparam logic [9:0] A_RSV  = 10'h3F3;

    int n_checks = 0;
    int n_pass   = 0;

    // Falling edges on the line, one per frame when the bytes are 0xFF.
    int   fall_cnt = 0;
    logic tx_prev  = 1'b1;
    always @(negedge clk) begin
        if (tx_prev === 1'b1 && tx === 1'b0) fall_cnt++;
        tx_prev = tx;
    end

    // Reference model: the frames that should appear back to back,
    // starting two edges after the first scheduled push, and the bus writes.
    logic [7:0]  frm_byte[$];
    int          frm_div[$];
    int          sc_k[$];
    logic [9:0]  sc_a[$];
    logic [31:0] sc_d[$];

    function automatic logic exp_tx(int k);
        int t;
        logic [7:0] b;
        if (k < 2) return 1'b1;
        t = k - 2;
        for (int i = 0; i < frm_byte.size(); i++) begin
            if (t < 10 * frm_div[i]) begin
                int pos;
                pos = t / frm_div[i];
                b = frm_byte[i];
                if (pos == 0) return 1'b0;
                if (pos == 9) return 1'b1;
                return b[pos-1];
            end
            t -= 10 * frm_div[i];
        end
        return 1'b1;
    endfunction

    function automatic int total_len();
        int s = 0;
        foreach (frm_div[i]) s += 10 * frm_div[i];
        return s;
    endfunction

    task automatic clear_model();
        frm_byte.delete(); frm_div.delete();
        sc_k.delete(); sc_a.delete(); sc_d.delete();
    endtask

    task automatic bus_write(input logic [9:0] a, input logic [31:0] d);
        bus.enable = 1'b1; bus.rw = 1'b1; bus.add = a; bus.wData = d;
        @(negedge clk);
        bus.enable = 1'b0; bus.rw = 1'b0;
    endtask

    task automatic bus_read(input logic [9:0] a, output logic [31:0] d, output logic h);
        bus.enable = 1'b1; bus.rw = 1'b0; bus.add = a;
        @(negedge clk);
        bus.enable = 1'b0;
        @(negedge clk);
        d = bus.rData;
        h = bus.hit;
    endtask

    task automatic run_wave(input string name, input int ncyc);
        int   bad_tx = -1, bad_irq = -1, total;
        logic got_tx = 1'b0, got_irq = 1'b0;
        total = total_len();
        for (int k = 0; k < ncyc; k++) begin
            logic etx, eirq;
            etx  = exp_tx(k);
            eirq = (k >= 1 && k < 2 + total) ? 1'b0 : 1'b1;
            if (bad_tx < 0 && tx !== etx) begin bad_tx = k; got_tx = tx; end
            if (bad_irq < 0 && irq !== eirq) begin bad_irq = k; got_irq = irq; end
            bus.enable = 1'b0; bus.rw = 1'b0;
            for (int j = 0; j < sc_k.size(); j++) begin
                if (sc_k[j] == k) begin
                    bus.enable = 1'b1; bus.rw = 1'b1; bus.add = sc_a[j]; bus.wData = sc_d[j];
                end
            end
            @(negedge clk);
        end
        bus.enable = 1'b0; bus.rw = 1'b0;
        n_checks++;
        if (bad_tx >= 0)
            $display("FAIL %s_tx: step %0d got %b expected %b", name, bad_tx, got_tx, exp_tx(bad_tx));
        else n_pass++;
        n_checks++;
        if (bad_irq >= 0)
            $display("FAIL %s_irq: step %0d got %b expected %b", name, bad_irq, got_irq, ~got_irq);
        else n_pass++;
    endtask

    task automatic test_reset();
        logic [31:0] d; logic h;
        reset = 1'b0;
        bus.enable = 1'b0; bus.rw = 1'b0; bus.add = 10'd0; bus.wData = 32'd0;
        repeat (3) @(negedge clk);
        n_checks++; if (tx !== 1'b1) $display("FAIL reset_tx: got %b expected 1", tx); else n_pass++;
        n_checks++; if (irq !== 1'b1) $display("FAIL reset_irq: got %b expected 1", irq); else n_pass++;
        n_checks++; if (bus.hit !== 1'b0) $display("FAIL reset_hit: got %b expected 0", bus.hit); else n_pass++;
        n_checks++; if (bus.rData !== 32'd0) $display("FAIL reset_rdata: got %h expected 0", bus.rData); else n_pass++;
        reset = 1'b1;
        @(negedge clk);
        bus_read(A_STAT, d, h);
        n_checks++; if (d !== 32'h4) $display("FAIL reset_status: got %h expected 00000004", d); else n_pass++;
        n_checks++; if (h !== 1'b1) $display("FAIL reset_status_hit: got %b expected 1", h); else n_pass++;
        @(negedge clk);
        n_checks++; if (bus.hit !== 1'b0) $display("FAIL hit_drop: got %b expected 0", bus.hit); else n_pass++;
        bus_read(A_DIV, d, h);
        n_checks++; if (d !== 32'd434) $display("FAIL reset_div: got %0d expected 434", d); else n_pass++;
        bus_read(A_RSV, d, h);
        n_checks++; if (d !== 32'd0 || h !== 1'b1) $display("FAIL rsv_read: got %h/%b expected 0/1", d, h); else n_pass++;
    endtask

    task automatic test_decode();
        logic [31:0] d; logic h;
        bus_read(10'h000, d, h);
        n_checks++; if (h !== 1'b0 || d !== 32'd0) $display("FAIL miss_read: got %h/%b expected 0/0", d, h); else n_pass++;
        bus_write(10'h000, 32'h41);
        bus_write(10'h3EF, 32'h42);
        bus_write(10'h3F4, 32'h43);
        bus_write(A_RSV, 32'hFFFF);
        @(negedge clk);
        n_checks++; if (irq !== 1'b1 || tx !== 1'b1) $display("FAIL miss_write_idle: got irq %b tx %b expected 1 1", irq, tx); else n_pass++;
        bus_read(A_STAT, d, h);
        n_checks++; if (d !== 32'h4) $display("FAIL miss_write_status: got %h expected 00000004", d); else n_pass++;
        bus_read(A_DIV, d, h);
        n_checks++; if (d !== 32'd434) $display("FAIL rsv_write_div: got %0d expected 434", d); else n_pass++;
        bus_read(A_DATA, d, h);
        n_checks++; if (d !== 32'd0 || h !== 1'b1) $display("FAIL data_read: got %h/%b expected 0/1", d, h); else n_pass++;
        bus_write(A_DIV, 32'hABCD0007);
        bus_read(A_DIV, d, h);
        n_checks++; if (d !== 32'd7) $display("FAIL div_upper_bits: got %h expected 00000007", d); else n_pass++;
    endtask

    task automatic test_frame_55();
        bus_write(A_DIV, 32'd4);
        clear_model();
        frm_byte.push_back(8'h55); frm_div.push_back(4);
        sc_k.push_back(0); sc_a.push_back(A_DATA); sc_d.push_back(32'h55);
        run_wave("frame55", 2 + 40 + 6);
    endtask

    task automatic test_div_zero();
        logic [31:0] d; logic h;
        bus_write(A_DIV, 32'd0);
        bus_read(A_DIV, d, h);
        n_checks++; if (d !== 32'd1) $display("FAIL div_zero_read: got %0d expected 1", d); else n_pass++;
        clear_model();
        frm_byte.push_back(8'hFF); frm_div.push_back(1);
        sc_k.push_back(0); sc_a.push_back(A_DATA); sc_d.push_back(32'hFF);
        run_wave("div1", 2 + 10 + 4);
    endtask

    task automatic test_overrun();
        logic [31:0] d; logic h;
        int base, waited;
        bus_write(A_DIV, 32'd2);
        base = fall_cnt;
        for (int i = 0; i < 6; i++) bus_write(A_DATA, 32'hFF);
        bus_read(A_STAT, d, h);
        n_checks++; if (d !== 32'h4B) $display("FAIL overrun_status: got %h expected 0000004b", d); else n_pass++;
        bus_read(A_STAT, d, h);
        n_checks++; if (d !== 32'h43) $display("FAIL overrun_cleared: got %h expected 00000043", d); else n_pass++;
        waited = 0;
        while (irq !== 1'b1 && waited < 400) begin @(negedge clk); waited++; end
        n_checks++; if (waited >= 400) $display("FAIL drain_timeout: irq %b after %0d cycles expected 1", irq, waited); else n_pass++;
        repeat (3) @(negedge clk);
        n_checks++; if (fall_cnt - base !== 5) $display("FAIL frames_sent: got %0d expected 5", fall_cnt - base); else n_pass++;
        bus_read(A_STAT, d, h);
        n_checks++; if (d !== 32'h4) $display("FAIL drained_status: got %h expected 00000004", d); else n_pass++;
    endtask

    task automatic test_div_midframe();
        logic [31:0] d; logic h;
        bus_write(A_DIV, 32'd4);
        clear_model();
        frm_byte.push_back(8'h3C); frm_div.push_back(4);
        frm_byte.push_back(8'hC3); frm_div.push_back(8);
        sc_k.push_back(0);  sc_a.push_back(A_DATA); sc_d.push_back(32'h3C);
        sc_k.push_back(10); sc_a.push_back(A_DIV);  sc_d.push_back(32'd8);
        sc_k.push_back(11); sc_a.push_back(A_DATA); sc_d.push_back(32'hC3);
        run_wave("div_change", 2 + 120 + 6);
        bus_read(A_DIV, d, h);
        n_checks++; if (d !== 32'd8) $display("FAIL div_change_read: got %0d expected 8", d); else n_pass++;
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            int div, n;
            div = int'($urandom_range(1, 5));
            n   = int'($urandom_range(1, 4));
            bus_write(A_DIV, 32'(div));
            clear_model();
            for (int i = 0; i < n; i++) begin
                logic [7:0] b;
                b = 8'($urandom_range(0, 255));
                frm_byte.push_back(b); frm_div.push_back(div);
                sc_k.push_back(i); sc_a.push_back(A_DATA); sc_d.push_back({24'd0, b});
            end
            run_wave($sformatf("rand%0d", it), 2 + 10 * div * n + 4);
        end
    endtask

    task automatic test_reset_midframe();
        logic [31:0] d; logic h;
        int base, bad;
        bus_write(A_DIV, 32'd4);
        bus_write(A_DATA, 32'hA5);
        bus_write(A_DATA, 32'h5A);
        repeat (17) @(negedge clk);
        n_checks++; if (tx !== 1'b0) $display("FAIL pre_reset_bit3: got %b expected 0", tx); else n_pass++;
        reset = 1'b0;
        #1;
        n_checks++; if (tx !== 1'b1) $display("FAIL async_reset_tx: got %b expected 1", tx); else n_pass++;
        n_checks++; if (irq !== 1'b1) $display("FAIL async_reset_irq: got %b expected 1", irq); else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        base = fall_cnt;
        bus_read(A_STAT, d, h);
        n_checks++; if (d !== 32'h4) $display("FAIL post_reset_status: got %h expected 00000004", d); else n_pass++;
        bus_read(A_DIV, d, h);
        n_checks++; if (d !== 32'd434) $display("FAIL post_reset_div: got %0d expected 434", d); else n_pass++;
        bad = 0;
        for (int k = 0; k < 100; k++) begin
            if (tx !== 1'b1) bad++;
            @(negedge clk);
        end
        n_checks++; if (bad != 0 || fall_cnt != base) $display("FAIL no_resume: got %0d low cycles %0d falls expected 0 0", bad, fall_cnt - base); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_decode();
        test_frame_55();
        test_div_zero();
        test_overrun();
        test_div_midframe();
        test_random();
        test_reset_midframe();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
